dma_bus_arbiter: RTL and testbench
==================================

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter TRIGGER_ADDR, default 16'h4014, CPU write address that starts a transfer.
REQ-002 SHALL have parameter DEST_ADDR, default 16'h2004, fixed write target for every copied byte.
REQ-003 SHALL have parameter LENGTH, default 256, bytes per transfer, legal range 1..256.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have port cpu_addr, input, 16, CPU address bus.
REQ-007 SHALL have port cpu_odata, input, 8, CPU write data.
REQ-008 SHALL have port cpu_rw, input, 1, CPU direction (1 = read, 0 = write).
REQ-009 SHALL have port bus_idata, input, 8, memory read data.
REQ-010 SHALL have port rdy, output, 1, CPU ready (0 = halt CPU).
REQ-011 SHALL have port bus_addr, output, 16, memory address.
REQ-012 SHALL have port bus_odata, output, 8, memory write data.
REQ-013 SHALL have port bus_rw, output, 1, memory direction (1 = read).
REQ-014 SHALL have port dma_busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE.
REQ-016 SHALL keep a phase bit toggling every clk, reset 0.
REQ-017 SHALL, in IDLE and HALT, drive bus_addr/bus_odata/bus_rw combinationally from cpu_addr/cpu_odata/cpu_rw (pass-through).
REQ-018 SHALL, in IDLE, on an edge sampling cpu_rw=0 and cpu_addr=TRIGGER_ADDR, latch page=cpu_odata, clear idx to 0, and enter HALT.
REQ-019 SHALL drive rdy=1 in IDLE only and rdy=0 in all other states.
REQ-020 SHALL remain in HALT while cpu_rw=0 and move to ALIGN on the first edge sampling cpu_rw=1, so CPU writes complete before the bus is taken.
REQ-021 SHALL ignore further TRIGGER_ADDR writes while in any non-IDLE state.
REQ-022 SHALL, in ALIGN, drive bus_rw=1, bus_addr=cpu_addr (dummy read) and bus_odata=cpu_odata.
REQ-023 SHALL leave ALIGN to READ on an edge where phase=1, so the first READ cycle always has phase=0; ALIGN therefore lasts 1 or 2 cycles.
REQ-024 SHALL, in READ, drive bus_addr={page, idx}, bus_rw=1, capture bus_idata into the data register at the cycle-ending edge, and go to WRITE.
REQ-025 SHALL, in WRITE, drive bus_addr=DEST_ADDR, bus_rw=0 and bus_odata=data register.
REQ-026 SHALL, at the end of each WRITE, increment idx (8-bit) and go to IDLE if idx was LENGTH-1, else go to READ.
REQ-027 SHALL keep source addresses within the latched page; idx never carries into page, and LENGTH=256 covers page:00..page:FF.
REQ-028 SHALL make a full transfer take 1+ cycles of HALT, 1-2 cycles of ALIGN and 2*LENGTH READ/WRITE cycles; rdy returns to 1 in the cycle after the last WRITE.

Reset
REQ-029 SHALL, while reset=0 and independent of clk, force state=IDLE, phase=0, idx=0, page=0, data=0, rdy=1 and dma_busy=0, with bus outputs in pass-through.
REQ-030 SHALL abort an in-progress transfer on reset assertion with no further DMA bus cycles; after release, operation restarts from IDLE.

Verification
REQ-031 SHALL verify a basic copy: memory $0200-$02FF=i^8'h5A, CPU writes 8'h02 to $4014 then reads -> 256 writes to $2004 with data 8'h5A,8'h5B,...,8'hA5 in order, then rdy=1.
REQ-032 SHALL verify alignment: trigger so that HALT exits with phase=0, and separately with phase=1 -> ALIGN lasts 2 and 1 cycles respectively, and the first READ always has phase=0 (total 514 vs 513 non-HALT cycles).
REQ-033 SHALL verify a write stall: after the trigger, the CPU issues two more writes (to $0010 and $0011) before a read -> both pass through unmodified with rdy=0, and DMA begins only after the read.
REQ-034 SHALL verify LENGTH=1: page 8'h03 with $0300=8'h81 -> exactly one READ of $0300 and one WRITE of 8'h81 to $2004, then IDLE.
REQ-035 SHALL verify reset mid-transfer: assert reset at idx=8'h40 -> rdy=1, dma_busy=0 and pass-through immediately; a fresh trigger after release restarts at idx=0.
REQ-036 SHALL verify re-trigger immunity: bus_idata forces writes to $4014 during the transfer -> page unchanged and exactly LENGTH writes occur.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: halts the CPU on a trigger write and copies one page of memory
// byte by byte to a fixed destination address, using alternating read/write bus cycles.
module dma_bus_arbiter #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int LENGTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_idata,
  output logic        rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_odata,
  output logic        bus_rw,
  output logic        dma_busy
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  localparam logic [7:0] LAST = 8'(LENGTH - 1);
  state_t state, state_nx;
  logic phase;
  logic [7:0] page, idx, data;
  assign rdy = state == IDLE;
  assign dma_busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      phase <= 1'b0;
      page <= '0;
      idx <= '0;
      data <= '0;
    end else begin
      state <= state_nx;
      phase <= ~phase;
      if (state == IDLE && state_nx == HALT) begin
        page <= cpu_odata;
        idx <= '0;
      end
      if (state == READ) data <= bus_idata;
      if (state == WRITE) idx <= idx + 8'd1;
    end
  // idx wraps within the page, so the source never leaves the latched page
  always_comb begin
    state_nx = state;
    bus_addr = cpu_addr;
    bus_odata = cpu_odata;
    bus_rw = cpu_rw;
    case (state)
      IDLE: state_nx = (!cpu_rw && cpu_addr == TRIGGER_ADDR) ? HALT : IDLE;
      HALT: state_nx = cpu_rw ? ALIGN : HALT;
      ALIGN: begin
        bus_rw = 1'b1;
        state_nx = phase ? READ : ALIGN;
      end
      READ: begin
        bus_addr = {page, idx};
        bus_rw = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        bus_addr = DEST_ADDR;
        bus_rw = 1'b0;
        bus_odata = data;
        state_nx = idx == LAST ? IDLE : READ;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: drives a 256-byte and a 1-byte instance from one CPU stimulus and
// checks every cycle against a transfer-level model plus hand-computed expectations.
module tb_dma_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_odata;
  logic cpu_rw;
  logic [1:0] rdy, rw, busy;
  logic [15:0] addr [2];
  logic [7:0] od [2];
  logic [7:0] idata [2];
  logic [7:0] mem [0:65535];
  int vec = 0, errs = 0, ecnt = 0, bcnt0 = 0, rq1 = 0;
  logic [7:0] wq0 [$];
  logic [7:0] wq1 [$];
  int md [2], n [2];
  int len [2] = '{256, 1};
  logic [7:0] pg [2];
  logic ph;
  logic [15:0] ea;
  logic [7:0] eo;
  logic er, chk_od;

  always #5 clk = ~clk;
  assign idata[0] = mem[addr[0]];
  assign idata[1] = mem[addr[1]];

  dma_bus_arbiter #(.LENGTH(256)) u0 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_odata(cpu_odata), .cpu_rw(cpu_rw),
    .bus_idata(idata[0]), .rdy(rdy[0]), .bus_addr(addr[0]), .bus_odata(od[0]),
    .bus_rw(rw[0]), .dma_busy(busy[0]));
  dma_bus_arbiter #(.LENGTH(1)) u1 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_odata(cpu_odata), .cpu_rw(cpu_rw),
    .bus_idata(idata[1]), .rdy(rdy[1]), .bus_addr(addr[1]), .bus_odata(od[1]),
    .bus_rw(rw[1]), .dma_busy(busy[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int u, input int lim);
    int c = 0;
    while (!rdy[u] && c < lim) begin
      tick;
      c++;
    end
    chk($sformatf("idle_timeout%0d", u), {31'd0, rdy[u]}, 1);
  endtask

  task automatic cpu(input logic [15:0] a, input logic w, input logic [7:0] d);
    cpu_addr = a;
    cpu_rw = w;
    cpu_odata = d;
  endtask

  task automatic start(input logic [7:0] p);
    wq0.delete();
    wq1.delete();
    bcnt0 = 0;
    rq1 = 0;
    cpu(16'h4014, 1'b0, p);
    tick;
    cpu(16'h8000, 1'b1, 8'h00);
    tick;
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) ecnt <= 0;
    else ecnt <= ecnt + 1;

  // Transfer-level model: a transfer is 2*len bus cycles, even ones read, odd ones write.
  always @(posedge clk or negedge reset)
    if (!reset) begin
      ph = 1'b0;
      for (int u = 0; u < 2; u++) begin
        md[u] = 0;
        n[u] = 0;
        pg[u] = 8'h00;
      end
    end else begin
      for (int u = 0; u < 2; u++)
        case (md[u])
          0: if (!cpu_rw && cpu_addr == 16'h4014) begin
            md[u] = 1;
            pg[u] = cpu_odata;
          end
          1: if (cpu_rw) md[u] = 2;
          2: if (ph) begin
            md[u] = 3;
            n[u] = 0;
          end
          default: begin
            n[u]++;
            if (n[u] == 2 * len[u]) md[u] = 0;
          end
        endcase
      ph = ~ph;
    end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ea = cpu_addr;
      er = cpu_rw;
      eo = cpu_odata;
      chk_od = 1'b1;
      if (md[u] == 2) er = 1'b1;
      if (md[u] == 3) begin
        if (n[u] % 2 == 0) begin
          ea = {pg[u], 8'(n[u] / 2)};
          er = 1'b1;
          chk_od = 1'b0;
        end else begin
          ea = 16'h2004;
          er = 1'b0;
          eo = mem[{pg[u], 8'(n[u] / 2)}];
        end
      end
      chk($sformatf("rdy%0d", u), {31'd0, rdy[u]}, {31'd0, md[u] == 0});
      chk($sformatf("busy%0d", u), {31'd0, busy[u]}, {31'd0, md[u] != 0});
      chk($sformatf("addr%0d", u), {16'd0, addr[u]}, {16'd0, ea});
      chk($sformatf("rw%0d", u), {31'd0, rw[u]}, {31'd0, er});
      if (chk_od) chk($sformatf("odata%0d", u), {24'd0, od[u]}, {24'd0, eo});
    end
    if (busy[0]) bcnt0++;
    if (busy[0] && !rw[0] && addr[0] == 16'h2004) wq0.push_back(od[0]);
    if (busy[1] && !rw[1] && addr[1] == 16'h2004) wq1.push_back(od[1]);
    if (busy[1] && rw[1] && addr[1] == 16'h0300) rq1++;
  end

  initial begin
    reset = 1'b0;
    cpu(16'h8000, 1'b1, 8'h00);
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + (i >> 8));
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    mem[16'h0300] = 8'h81;
    mem[16'h0500] = 8'h40;
    mem[16'h0501] = 8'h14;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_rdy", {31'd0, rdy[0]}, 1);
    chk("reset_busy", {31'd0, busy[0]}, 0);
    chk("reset_addr", {16'd0, addr[0]}, 32'h8000);
    reset = 1'b1;
    tick;
    // trigger edge even-numbered: ALIGN lasts 1 cycle
    while (ecnt % 2 != 1) tick;
    start(8'h02);
    wait_idle(0, 700);
    chk("copy_count", wq0.size(), 256);
    chk("copy_first", {24'd0, wq0[0]}, 32'h5A);
    chk("copy_second", {24'd0, wq0[1]}, 32'h5B);
    chk("copy_last", {24'd0, wq0[255]}, 32'hA5);
    chk("align_short_busy", bcnt0, 514);
    // trigger edge odd-numbered: ALIGN lasts 2 cycles
    while (ecnt % 2 != 0) tick;
    start(8'h02);
    wait_idle(0, 700);
    chk("align_long_busy", bcnt0, 515);
    chk("align_long_count", wq0.size(), 256);
    wq0.delete();
    cpu(16'h4014, 1'b0, 8'h02);
    tick;
    cpu(16'h0010, 1'b0, 8'h11);
    #1;
    chk("stall1_addr", {16'd0, addr[0]}, 32'h0010);
    chk("stall1_data", {24'd0, od[0]}, 32'h11);
    chk("stall1_rw", {31'd0, rw[0]}, 0);
    chk("stall1_rdy", {31'd0, rdy[0]}, 0);
    tick;
    cpu(16'h0011, 1'b0, 8'h22);
    #1;
    chk("stall2_addr", {16'd0, addr[0]}, 32'h0011);
    chk("stall2_data", {24'd0, od[0]}, 32'h22);
    chk("stall2_rdy", {31'd0, rdy[0]}, 0);
    tick;
    chk("stall_no_write", wq0.size(), 0);
    cpu(16'h8000, 1'b1, 8'h00);
    wait_idle(0, 700);
    chk("stall_count", wq0.size(), 256);
    start(8'h03);
    wait_idle(1, 20);
    chk("len1_reads", rq1, 1);
    chk("len1_writes", wq1.size(), 1);
    chk("len1_data", {24'd0, wq1[0]}, 32'h81);
    wait_idle(0, 700);
    start(8'h02);
    for (int c = 0; c < 700 && wq0.size() < 64; c++) tick;
    chk("mid_reached", wq0.size(), 64);
    reset = 1'b0;
    #1;
    chk("mid_rdy", {31'd0, rdy[0]}, 1);
    chk("mid_busy", {31'd0, busy[0]}, 0);
    chk("mid_addr", {16'd0, addr[0]}, 32'h8000);
    chk("mid_rw", {31'd0, rw[0]}, 1);
    tick;
    reset = 1'b1;
    tick;
    start(8'h04);
    wait_idle(0, 700);
    chk("restart_count", wq0.size(), 256);
    chk("restart_first", {24'd0, wq0[0]}, {24'd0, mem[16'h0400]});
    wq0.delete();
    cpu(16'h4014, 1'b0, 8'h05);
    tick;
    cpu(16'h8000, 1'b1, 8'h00);
    tick;
    cpu(16'h4014, 1'b0, 8'h99);
    wait_idle(0, 700);
    cpu(16'h8000, 1'b1, 8'h00);
    chk("retrig_count", wq0.size(), 256);
    chk("retrig_first", {24'd0, wq0[0]}, 32'h40);
    chk("retrig_second", {24'd0, wq0[1]}, 32'h14);
    chk("retrig_last", {24'd0, wq0[255]}, {24'd0, mem[16'h05FF]});
    tick;
    wait_idle(1, 20);
    wait_idle(0, 700);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
